// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the sync_fifo_wl family.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : read-mode selectors for FWFT_EN
//   clog2()                        : ceiling log2, for elaboration-time sizing
//   cnt_width()                    : width of a level counter that must hold
//                                    0..2**depth_width inclusive
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

   localparam bit FIFO_MODE_STD  = 1'b0;
   localparam bit FIFO_MODE_FWFT = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

   // A full FIFO holds exactly 2**depth_width words, so the count needs one
   // bit more than the pointers.
   function automatic int cnt_width(input int depth_width);
      return depth_width + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port RAM: one write port, one read port with a registered output.
// Kept on its own so a vendor memory primitive can replace it later.
//   clk      : clock
//   rst      : asynchronous active-high reset (output register only)
//   clr      : synchronous clear of the output register
//   wr_en    : write strobe        wr_addr / wr_data : write address / data
//   rd_en    : read strobe         rd_addr           : read address
//   rd_q     : registered read data, RST_DATA after rst/clr, holds otherwise
// A read and a write to the same address in one cycle return the old word.
// -----------------------------------------------------------------------------
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    DEPTH      = 1024,
   parameter logic [DATA_WIDTH-1:0] RST_DATA   = '0,
   localparam int                   ADDR_W     = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_q
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto block RAM; the FIFO
   // never reads a location before writing it, so its power-up contents are moot.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, which also gives read-before-write here.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= RST_DATA;
      end else if (clr) begin
         rd_q <= RST_DATA;
      end else if (rd_en) begin
         rd_q <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sync_fifo_wl.sv
// -----------------------------------------------------------------------------
// sync_fifo_wl
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, a live water level, synchronous flush
// and sticky overflow/underflow flags.
//   clk, rst          : clock, asynchronous active-high reset
//   clr               : synchronous flush (wins over wr_en/rd_en)
//   wr_en, wr_data    : write request and data;   wr_full, almost_full
//   rd_en, rd_data    : read request (FWFT: pop);  rd_empty, almost_empty
//   water_level       : words held (FWFT: includes the word on rd_data)
//   af_thresh         : almost_full  = water_level >= af_thresh
//   ae_thresh         : almost_empty = water_level <= ae_thresh
//   overflow          : sticky, write dropped while full
//   underflow         : sticky, read attempted while empty
// All flags are registered from the next-cycle count, so they line up with
// water_level.
// -----------------------------------------------------------------------------
module sync_fifo_wl
   import sync_fifo_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    DEPTH_WIDTH = 10,
   parameter bit                    FWFT_EN     = FIFO_MODE_STD,
   parameter logic [DATA_WIDTH-1:0] RST_DATA    = '0,
   localparam int                   CNT_W       = cnt_width(DEPTH_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  wr_full,
   output logic                  almost_full,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_en,
   output logic                  rd_empty,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      water_level,
   input  logic [CNT_W-1:0]      af_thresh,
   input  logic [CNT_W-1:0]      ae_thresh,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int               DEPTH    = 1 << DEPTH_WIDTH;
   localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(DEPTH);

   logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
   logic [CNT_W-1:0]       level_next, ram_words, level_d;
   logic                   pf_valid, pf_valid_next, pf_valid_d;
   logic                   rd_acc, wr_acc, ram_rd, ram_we, ram_re;
   logic                   wr_full_d, almost_full_d, rd_empty_d, almost_empty_d;
   logic                   overflow_d, underflow_d;

   always_comb begin
      // NOTE: every signal assigned here gets a value on every path first,
      // otherwise synthesis infers latches for the missing cases.
      rd_acc        = rd_en & ~rd_empty;
      wr_acc        = wr_en & (~wr_full | rd_acc);
      ram_words     = water_level - CNT_W'(pf_valid);
      ram_rd        = rd_acc;
      pf_valid_next = 1'b0;

      // In FWFT mode the RAM output register is the prefetch slot: refill it
      // whenever it is empty or being popped and the RAM still has words.
      if (FWFT_EN == FIFO_MODE_FWFT) begin
         ram_rd        = (ram_words != '0) & (~pf_valid | rd_acc);
         pf_valid_next = ram_rd | (pf_valid & ~rd_acc);
      end

      level_next = water_level;
      if (wr_acc && !rd_acc) begin
         level_next = water_level + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
         level_next = water_level - CNT_W'(1);
      end

      wr_ptr_d       = wr_acc ? wr_ptr + DEPTH_WIDTH'(1) : wr_ptr;
      rd_ptr_d       = ram_rd ? rd_ptr + DEPTH_WIDTH'(1) : rd_ptr;
      level_d        = level_next;
      pf_valid_d     = pf_valid_next;
      wr_full_d      = (level_next == CAPACITY);
      almost_full_d  = (level_next >= af_thresh);
      rd_empty_d     = (FWFT_EN == FIFO_MODE_FWFT) ? ~pf_valid_next
                                                   : (level_next == '0);
      almost_empty_d = (level_next <= ae_thresh);
      overflow_d     = overflow  | (wr_en & ~wr_acc);
      underflow_d    = underflow | (rd_en & rd_empty);

      if (clr) begin
         wr_ptr_d       = '0;
         rd_ptr_d       = '0;
         level_d        = '0;
         pf_valid_d     = 1'b0;
         wr_full_d      = 1'b0;
         almost_full_d  = 1'b0;
         rd_empty_d     = 1'b1;
         almost_empty_d = 1'b1;
         overflow_d     = 1'b0;
         underflow_d    = 1'b0;
      end

      ram_we = wr_acc & ~clr;
      ram_re = ram_rd & ~clr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         water_level  <= '0;
         pf_valid     <= 1'b0;
         wr_full      <= 1'b0;
         almost_full  <= 1'b0;
         rd_empty     <= 1'b1;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_d;
         rd_ptr       <= rd_ptr_d;
         water_level  <= level_d;
         pf_valid     <= pf_valid_d;
         wr_full      <= wr_full_d;
         almost_full  <= almost_full_d;
         rd_empty     <= rd_empty_d;
         almost_empty <= almost_empty_d;
         overflow     <= overflow_d;
         underflow    <= underflow_d;
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .RST_DATA   (RST_DATA)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (ram_re),
      .rd_addr (rd_ptr),
      .rd_q    (rd_data)
   );

endmodule

// File: tb/tb_sync_fifo_wl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_wl
// Two 16-deep, 16-bit instances: u_std (standard read) and u_fwft (FWFT).
// Writes push expected words into a queue; monitors on the falling edge pop
// and compare whenever a read result is due. Directed checks cover the
// boundary cases (full, empty, thresholds, flush, async reset, wrap).
// -----------------------------------------------------------------------------
module tb_sync_fifo_wl;

   localparam int          DW      = 16;
   localparam int          AW      = 4;
   localparam int          CAP     = 16;
   localparam logic [15:0] RST_VAL = 16'hA5A5;

   logic clk    = 1'b0;
   logic tb_rst = 1'b1;

   // standard-mode instance
   logic          s_clr, s_wr_en, s_rd_en;
   logic [DW-1:0] s_wr_data, s_rd_data;
   logic          s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
   logic [AW:0]   s_level, s_af_th, s_ae_th;

   // FWFT-mode instance
   logic          f_clr, f_wr_en, f_rd_en;
   logic [DW-1:0] f_wr_data, f_rd_data;
   logic          f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
   logic [AW:0]   f_level, f_af_th, f_ae_th;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_EN(1'b0), .RST_DATA(RST_VAL)) u_std (
      .clk(clk), .rst(tb_rst), .clr(s_clr),
      .wr_data(s_wr_data), .wr_en(s_wr_en), .wr_full(s_full), .almost_full(s_af),
      .rd_data(s_rd_data), .rd_en(s_rd_en), .rd_empty(s_empty), .almost_empty(s_ae),
      .water_level(s_level), .af_thresh(s_af_th), .ae_thresh(s_ae_th),
      .overflow(s_ovf), .underflow(s_unf));

   sync_fifo_wl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_EN(1'b1), .RST_DATA(RST_VAL)) u_fwft (
      .clk(clk), .rst(tb_rst), .clr(f_clr),
      .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_full(f_full), .almost_full(f_af),
      .rd_data(f_rd_data), .rd_en(f_rd_en), .rd_empty(f_empty), .almost_empty(f_ae),
      .water_level(f_level), .af_thresh(f_af_th), .ae_thresh(f_ae_th),
      .overflow(f_ovf), .underflow(f_unf));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- standard-mode reference model + scoreboard -------------
   int          m_lvl;
   bit          m_ovf, m_unf, m_af, m_ae, m_ra, m_wa, rd_due;
   logic [15:0] exp_q[$];
   logic [15:0] exp_head;

   initial forever begin
      @(posedge clk or posedge tb_rst);
      if (tb_rst || s_clr) begin
         m_lvl = 0; m_ovf = 0; m_unf = 0; m_af = 0; m_ae = 1; rd_due = 0;
         exp_q.delete();
      end else begin
         m_ra = s_rd_en && (m_lvl != 0);
         m_wa = s_wr_en && ((m_lvl != CAP) || m_ra);
         if (s_wr_en && !m_wa) m_ovf = 1;
         if (s_rd_en && m_lvl == 0) m_unf = 1;
         if (m_ra) begin
            exp_head = exp_q.pop_front();
            rd_due   = 1;
         end
         if (m_wa) exp_q.push_back(s_wr_data);
         m_lvl = m_lvl + int'(m_wa) - int'(m_ra);
         m_af  = (m_lvl >= int'(s_af_th));
         m_ae  = (m_lvl <= int'(s_ae_th));
      end
   end

   initial forever begin
      @(negedge clk);
      if (!tb_rst) begin
         check("std_level", 32'(s_level), 32'(m_lvl));
         check("std_full",  32'(s_full),  32'(m_lvl == CAP));
         check("std_empty", 32'(s_empty), 32'(m_lvl == 0));
         check("std_af",    32'(s_af),    32'(m_af));
         check("std_ae",    32'(s_ae),    32'(m_ae));
         check("std_ovf",   32'(s_ovf),   32'(m_ovf));
         check("std_unf",   32'(s_unf),   32'(m_unf));
         if (rd_due) begin
            check("std_rd_data", 32'(s_rd_data), 32'(exp_head));
            rd_due = 0;
         end
      end
   end

   // ---------------- FWFT scoreboard: head word must be on rd_data at pop ----
   logic [15:0] exp_q_f[$];

   initial forever begin
      @(negedge clk);
      if (!tb_rst && f_rd_en && exp_q_f.size() != 0) begin
         check("fwft_empty_at_pop", 32'(f_empty), 32'(0));
         check("fwft_rd_data", 32'(f_rd_data), 32'(exp_q_f.pop_front()));
      end
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic s_cyc(input logic wr, input logic [15:0] d, input logic rd);
      s_wr_en = wr; s_wr_data = d; s_rd_en = rd;
      @(posedge clk); #1;
      s_wr_en = 1'b0; s_rd_en = 1'b0;
   endtask

   task automatic s_flush();
      s_clr = 1'b1;
      @(posedge clk); #1;
      s_clr = 1'b0;
   endtask

   task automatic f_cyc(input logic wr, input logic [15:0] d, input logic rd);
      f_wr_en = wr; f_wr_data = d; f_rd_en = rd;
      if (wr) exp_q_f.push_back(d);
      @(posedge clk); #1;
      f_wr_en = 1'b0; f_rd_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      s_clr = 0; s_wr_en = 0; s_rd_en = 0; s_wr_data = '0;
      f_clr = 0; f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
      s_af_th = 5'd12; s_ae_th = 5'd3;
      f_af_th = 5'd12; f_ae_th = 5'd3;

      // ---- reset values ----
      repeat (2) @(posedge clk);
      #1;
      check("rst_level",   32'(s_level),   32'(0));
      check("rst_empty",   32'(s_empty),   32'(1));
      check("rst_full",    32'(s_full),    32'(0));
      check("rst_af",      32'(s_af),      32'(0));
      check("rst_ae",      32'(s_ae),      32'(1));
      check("rst_rd_data", 32'(s_rd_data), 32'(RST_VAL));
      check("rst_ovf",     32'(s_ovf),     32'(0));
      check("rst_unf",     32'(s_unf),     32'(0));
      check("rst_f_empty", 32'(f_empty),   32'(1));
      check("rst_f_data",  32'(f_rd_data), 32'(RST_VAL));
      check("rst_f_flags", 32'({f_full, f_af, f_ae, f_ovf, f_unf}), 32'(5'b00100));
      tb_rst = 1'b0;
      tick();

      // ---- FWFT: single word, 2-cycle fall-through, then one pop ----
      f_cyc(1'b1, 16'h1234, 1'b0);
      check("fwft_empty_1cyc", 32'(f_empty), 32'(1));
      tick();
      check("fwft_empty_2cyc", 32'(f_empty),   32'(0));
      check("fwft_data_2cyc",  32'(f_rd_data), 32'h1234);
      check("fwft_level_1",    32'(f_level),   32'(1));
      f_cyc(1'b0, 16'h0, 1'b1);
      check("fwft_empty_pop",  32'(f_empty), 32'(1));
      check("fwft_level_pop",  32'(f_level), 32'(0));

      // ---- FWFT: three words popped back-to-back ----
      f_cyc(1'b1, 16'hA001, 1'b0);
      f_cyc(1'b1, 16'hA002, 1'b0);
      f_cyc(1'b1, 16'hA003, 1'b0);
      tick();
      check("fwft_level_3", 32'(f_level),   32'(3));
      check("fwft_head",    32'(f_rd_data), 32'hA001);
      f_cyc(1'b0, 16'h0, 1'b1);
      check("fwft_next_2",  32'(f_rd_data), 32'hA002);
      f_cyc(1'b0, 16'h0, 1'b1);
      check("fwft_next_3",  32'(f_rd_data), 32'hA003);
      check("fwft_nonempty", 32'(f_empty), 32'(0));
      f_cyc(1'b0, 16'h0, 1'b1);
      check("fwft_drained", 32'(f_empty), 32'(1));
      check("fwft_ovf_unf", 32'({f_ovf, f_unf}), 32'(0));

      // ---- 1: fill, overflow, drain, underflow ----
      for (int i = 0; i < 16; i++) s_cyc(1'b1, 16'(16'hFFFF - i), 1'b0);
      check("t1_full",  32'(s_full),  32'(1));
      check("t1_level", 32'(s_level), 32'(16));
      s_cyc(1'b1, 16'h0BAD, 1'b0);
      check("t1_ovf",        32'(s_ovf),   32'(1));
      check("t1_level_ovf",  32'(s_level), 32'(16));
      for (int i = 0; i < 16; i++) begin
         s_cyc(1'b0, 16'h0, 1'b1);
         check("t1_rd", 32'(s_rd_data), 32'(16'(16'hFFFF - i)));
      end
      check("t1_empty", 32'(s_empty), 32'(1));
      s_cyc(1'b0, 16'h0, 1'b1);
      check("t1_unf",  32'(s_unf),     32'(1));
      check("t1_hold", 32'(s_rd_data), 32'hFFF0);

      // ---- 3: full FIFO, simultaneous read/write for 8 cycles ----
      s_flush();
      check("t3_clr_flags", 32'({s_ovf, s_unf}), 32'(0));
      for (int i = 0; i < 16; i++) s_cyc(1'b1, 16'(16'h3000 + i), 1'b0);
      for (int i = 0; i < 8; i++) begin
         s_cyc(1'b1, 16'(16'h3100 + i), 1'b1);
         check("t3_level", 32'(s_level),   32'(16));
         check("t3_rd",    32'(s_rd_data), 32'(16'(16'h3000 + i)));
      end
      check("t3_ovf", 32'(s_ovf), 32'(0));
      for (int i = 0; i < 16; i++) begin
         s_cyc(1'b0, 16'h0, 1'b1);
         check("t3_drain", 32'(s_rd_data),
               32'(i < 8 ? 16'(16'h3008 + i) : 16'(16'h3100 + i - 8)));
      end

      // ---- 4: thresholds af=12, ae=3 across the full range ----
      check("t4_af_0", 32'(s_af), 32'(0));
      check("t4_ae_0", 32'(s_ae), 32'(1));
      for (int k = 1; k <= 16; k++) begin
         s_cyc(1'b1, 16'(16'h4000 + k), 1'b0);
         check("t4_up_level", 32'(s_level), 32'(k));
         check("t4_up_af",    32'(s_af),    32'(k >= 12));
         check("t4_up_ae",    32'(s_ae),    32'(k <= 3));
      end
      for (int k = 15; k >= 0; k--) begin
         s_cyc(1'b0, 16'h0, 1'b1);
         check("t4_dn_level", 32'(s_level), 32'(k));
         check("t4_dn_af",    32'(s_af),    32'(k >= 12));
         check("t4_dn_ae",    32'(s_ae),    32'(k <= 3));
      end

      // ---- 5: flush with 7 words and overflow set, write in the same cycle ----
      for (int i = 0; i < 16; i++) s_cyc(1'b1, 16'(16'h5000 + i), 1'b0);
      s_cyc(1'b1, 16'h5BAD, 1'b0);
      for (int i = 0; i < 9; i++) s_cyc(1'b0, 16'h0, 1'b1);
      check("t5_level_7", 32'(s_level), 32'(7));
      check("t5_ovf_set", 32'(s_ovf),   32'(1));
      s_clr = 1'b1; s_wr_en = 1'b1; s_wr_data = 16'hDEAD;
      @(posedge clk); #1;
      s_clr = 1'b0; s_wr_en = 1'b0;
      check("t5_clr_level", 32'(s_level),   32'(0));
      check("t5_clr_empty", 32'(s_empty),   32'(1));
      check("t5_clr_ovf",   32'(s_ovf),     32'(0));
      check("t5_clr_data",  32'(s_rd_data), 32'(RST_VAL));
      tick();
      check("t5_wr_dropped", 32'(s_level), 32'(0));

      // async reset in the middle of a burst, no clock edge needed
      s_cyc(1'b1, 16'h6000, 1'b0);
      s_cyc(1'b1, 16'h6001, 1'b1);
      check("t5_pre_rst_data", 32'(s_rd_data), 32'h6000);
      s_wr_en = 1'b1; s_wr_data = 16'h6002;
      @(posedge clk); #2;
      tb_rst = 1'b1;
      #1;
      check("t5_arst_level", 32'(s_level),   32'(0));
      check("t5_arst_empty", 32'(s_empty),   32'(1));
      check("t5_arst_full",  32'(s_full),    32'(0));
      check("t5_arst_data",  32'(s_rd_data), 32'(RST_VAL));
      check("t5_arst_ae",    32'(s_ae),      32'(1));
      s_wr_en = 1'b0;
      #1;
      tb_rst = 1'b0;
      tick();

      // ---- 6: 50 write/read pairs, pointers pass 16, 32 and 48 ----
      for (int i = 0; i < 50; i++) begin
         s_cyc(1'b1, 16'(16'h7000 + i), 1'b0);
         check("t6_level_1", 32'(s_level), 32'(1));
         s_cyc(1'b0, 16'h0, 1'b1);
         check("t6_level_0", 32'(s_level),   32'(0));
         check("t6_rd",      32'(s_rd_data), 32'(16'(16'h7000 + i)));
      end
      check("t6_flags", 32'({s_ovf, s_unf}), 32'(0));

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
